// File: rtl/bcd_timer_pkg.sv
// Shared constants and helpers for the BCD play timer and its digit counters.
package bcd_timer_pkg;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Limit a preload digit to the digit's legal range.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] value,
                                             input logic [3:0] max_val);
        return (value > max_val) ? max_val : value;
    endfunction

    // Prescaler width; never below one bit so CLK_DIV=1 still has a register.
    function automatic int unsigned prescaler_width(input int unsigned clk_div);
        int unsigned w;
        w = int'($clog2(clk_div));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with up/down stepping, clamped preload and chain outputs.
module bcd_digit_counter
    import bcd_timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       down,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       carry_out,
    output logic       borrow_out
);

    // Digit register: reset, then preload, then step.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 4'd0;
        end else if (load) begin
            q <= bcd_clamp(load_val, MAX);
        end else if (en) begin
            if (down) begin
                q <= (q == 4'd0) ? MAX : q - 4'd1;
            end else begin
                q <= (q == MAX) ? 4'd0 : q + 4'd1;
            end
        end
    end

    // Ripple into the next digit when this one rolls over in either direction.
    assign carry_out  = en & ~down & (q == MAX);
    assign borrow_out = en &  down & (q == 4'd0);

endmodule

// File: rtl/bcd_play_timer.sv
// mm:ss BCD elapsed/remaining timer with prescaler, preload and wrap/saturate.
module bcd_play_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 100,
    parameter int unsigned MIN_DIGITS = 2,
    parameter bit          WRAP       = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    count,
    input  logic                    mode_down,
    input  logic                    load,
    input  logic [3:0]              load_seconds0,
    input  logic [3:0]              load_seconds1,
    input  logic [4*MIN_DIGITS-1:0] load_minutes,
    output logic [3:0]              seconds0,
    output logic [3:0]              seconds1,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic                    tick,
    output logic                    done,
    output logic                    wrap
);

    localparam int unsigned PW         = prescaler_width(CLK_DIV);
    localparam int unsigned NUM_DIGITS = 2 + MIN_DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]         prescaler;
    logic                  last_c;
    logic                  tick_event_c;
    logic                  terminal_c;
    logic                  is_max_c;
    logic                  is_zero_c;
    logic [NUM_DIGITS:0]   en_chain;
    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] at_zero;
    logic [NUM_DIGITS-1:0] carry;
    logic [NUM_DIGITS-1:0] borrow;
    logic [3:0]            digit_q [NUM_DIGITS];

    // A second elapses on this edge unless load or reset takes precedence.
    assign last_c       = (prescaler == PRESC_LAST);
    assign tick_event_c = count & last_c & ~load & ~reset;

    // Terminal value: 0:00 counting down, or max when saturating up.
    assign is_max_c   = &at_max;
    assign is_zero_c  = &at_zero;
    assign terminal_c = mode_down ? is_zero_c : ((WRAP == 1'b0) & is_max_c);
    assign done       = terminal_c;

    // Digits only step on a tick while the value is not terminal.
    assign en_chain[0] = tick_event_c & ~terminal_c;

    // Prescaler and registered tick/wrap pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end else if (load) begin
            prescaler <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            tick <= tick_event_c;
            // A carry out of the top digit only happens on an up-mode rollover.
            wrap <= en_chain[NUM_DIGITS] & ~mode_down;
            if (count) begin
                prescaler <= last_c ? '0 : prescaler + PW'(1);
            end
        end
    end

    // Digit chain: seconds units, seconds tens, then minute digits upward.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam logic [3:0] DMAX = (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;

        logic [3:0] load_val;

        if (i == 0) begin : g_sec0
            assign load_val = load_seconds0;
        end else if (i == 1) begin : g_sec1
            assign load_val = load_seconds1;
        end else begin : g_min
            assign load_val = load_minutes[4*(i-2) +: 4];
            assign minutes[4*(i-2) +: 4] = digit_q[i];
        end

        bcd_digit_counter #(
            .MAX (DMAX)
        ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .en         (en_chain[i]),
            .down       (mode_down),
            .load       (load),
            .load_val   (load_val),
            .q          (digit_q[i]),
            .carry_out  (carry[i]),
            .borrow_out (borrow[i])
        );

        assign at_max[i]     = (digit_q[i] == DMAX);
        assign at_zero[i]    = (digit_q[i] == 4'd0);
        assign en_chain[i+1] = carry[i] | borrow[i];
    end

    assign seconds0 = digit_q[0];
    assign seconds1 = digit_q[1];

endmodule

// File: tb/tb_bcd_play_timer.sv
// Self-checking bench: WRAP=0 and WRAP=1 instances against a seconds-count model.
module tb_bcd_play_timer;

    localparam int CLK_DIV = 4;
    localparam int MAXS    = 99*60 + 59;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       count = 1'b0;
    logic       mode_down = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld_s0 = 4'd0;
    logic [3:0] ld_s1 = 4'd0;
    logic [7:0] ld_min = 8'd0;

    logic [3:0] s0_a, s1_a, s0_b, s1_b;
    logic [7:0] min_a, min_b;
    logic       tick_a, done_a, wrap_a, tick_b, done_b, wrap_b;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed value as plain seconds per instance.
    int m_secs [2];
    int m_presc;
    bit m_tick;
    bit m_wrap [2];

    always #5 clk = ~clk;

    bcd_play_timer #(.CLK_DIV(CLK_DIV), .MIN_DIGITS(2), .WRAP(1'b0)) dut_a (
        .clk(clk), .reset(reset), .count(count), .mode_down(mode_down), .load(load),
        .load_seconds0(ld_s0), .load_seconds1(ld_s1), .load_minutes(ld_min),
        .seconds0(s0_a), .seconds1(s1_a), .minutes(min_a),
        .tick(tick_a), .done(done_a), .wrap(wrap_a));

    bcd_play_timer #(.CLK_DIV(CLK_DIV), .MIN_DIGITS(2), .WRAP(1'b1)) dut_b (
        .clk(clk), .reset(reset), .count(count), .mode_down(mode_down), .load(load),
        .load_seconds0(ld_s0), .load_seconds1(ld_s1), .load_minutes(ld_min),
        .seconds0(s0_b), .seconds1(s1_b), .minutes(min_b),
        .tick(tick_b), .done(done_b), .wrap(wrap_b));

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int load_secs();
        int m1, m0;
        m1 = clampi(int'(ld_min[7:4]), 9);
        m0 = clampi(int'(ld_min[3:0]), 9);
        return (m1*10 + m0)*60 + clampi(int'(ld_s1), 5)*10 + clampi(int'(ld_s0), 9);
    endfunction

    // Advance the model by one clock edge using the inputs applied before it.
    task automatic model_edge();
        bit ev;
        ev = count && (m_presc == CLK_DIV - 1);
        if (reset) begin
            m_presc = 0; m_tick = 0;
            for (int k = 0; k < 2; k++) begin m_secs[k] = 0; m_wrap[k] = 0; end
        end else if (load) begin
            m_presc = 0; m_tick = 0;
            for (int k = 0; k < 2; k++) begin m_secs[k] = load_secs(); m_wrap[k] = 0; end
        end else begin
            m_tick = ev;
            if (count) m_presc = ev ? 0 : m_presc + 1;
            for (int k = 0; k < 2; k++) begin
                m_wrap[k] = 0;
                if (ev) begin
                    if (mode_down) begin
                        if (m_secs[k] > 0) m_secs[k]--;
                    end else if (m_secs[k] == MAXS) begin
                        if (k == 1) begin m_secs[k] = 0; m_wrap[k] = 1; end
                    end else begin
                        m_secs[k]++;
                    end
                end
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [18:0] obs(input int k);
        if (k == 0) return {min_a, s1_a, s0_a, tick_a, done_a, wrap_a};
        return {min_b, s1_b, s0_b, tick_b, done_b, wrap_b};
    endfunction

    function automatic logic [18:0] expv(input int k);
        int s, m;
        bit d;
        s = m_secs[k];
        m = s / 60;
        d = mode_down ? (s == 0) : (k == 0 && s == MAXS);
        return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10), m_tick, d, m_wrap[k]};
    endfunction

    task automatic test_reset();
        reset = 1; load = 1; count = 1; ld_s0 = 4'd9; ld_s1 = 4'd5; ld_min = 8'h99;
        clk_step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin errors++;
                $display("FAIL reset dut%0d got %h want %h", k, obs(k), expv(k)); end
        end
        mode_down = 1;
        clk_step();
        checks++;
        if ({done_a, done_b, s0_a, min_a} !== {1'b1, 1'b1, 4'd0, 8'h00}) begin errors++;
            $display("FAIL reset_down got done=%b%b s0=%h min=%h want done=11 zeros",
                     done_a, done_b, s0_a, min_a); end
        reset = 0; load = 0; count = 0; mode_down = 0;
    endtask

    task automatic test_count_up();
        int nt = 0;
        reset = 1; clk_step(); reset = 0; count = 1;
        for (int c = 0; c < 40; c++) begin
            clk_step();
            nt += int'(tick_a);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin errors++;
                    $display("FAIL count_up c%0d dut%0d got %h want %h", c, k, obs(k), expv(k)); end
            end
        end
        checks++;
        if (nt != 10 || {min_a, s1_a, s0_a} !== 16'h0010 || done_a !== 1'b0) begin errors++;
            $display("FAIL count_up_total ticks=%0d val=%h done=%b want 10 0010 0",
                     nt, {min_a, s1_a, s0_a}, done_a); end
    endtask

    task automatic test_pause();
        int first = -1;
        clk_step(); clk_step();
        count = 0;
        for (int c = 0; c < 20; c++) begin
            clk_step();
            checks++;
            if (obs(0) !== expv(0) || {min_a, s1_a, s0_a} !== 16'h0010) begin errors++;
                $display("FAIL pause c%0d got %h want %h", c, obs(0), expv(0)); end
        end
        count = 1;
        for (int c = 1; c <= 4; c++) begin
            clk_step();
            if (tick_a && first < 0) first = c;
            checks++;
            if (obs(1) !== expv(1)) begin errors++;
                $display("FAIL resume c%0d got %h want %h", c, obs(1), expv(1)); end
        end
        checks++;
        if (first != 2) begin errors++;
            $display("FAIL resume_latency got %0d want 2", first); end
    endtask

    task automatic test_sat_wrap();
        int nw = 0;
        mode_down = 0; load = 1; ld_s0 = 4'd8; ld_s1 = 4'd5; ld_min = 8'h99;
        clk_step(); load = 0; count = 1;
        for (int c = 1; c <= 16; c++) begin
            clk_step();
            nw += int'(wrap_b);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin errors++;
                    $display("FAIL sat_wrap c%0d dut%0d got %h want %h", c, k, obs(k), expv(k)); end
            end
            if (c == 8) begin
                checks++;
                if ({min_a, s1_a, s0_a, done_a} !== {16'h9959, 1'b1} ||
                    {min_b, s1_b, s0_b, tick_b, wrap_b, done_b} !== {16'h0000, 3'b110}) begin
                    errors++;
                    $display("FAIL sat_wrap_2nd a=%h%b b=%h t%b w%b d%b want a=99591 b=0000 t1 w1 d0",
                             {min_a, s1_a, s0_a}, done_a, {min_b, s1_b, s0_b}, tick_b, wrap_b, done_b);
                end
            end
        end
        checks++;
        if (nw != 1 || {min_a, s1_a, s0_a} !== 16'h9959) begin errors++;
            $display("FAIL sat_hold wraps=%0d a=%h want 1 9959", nw, {min_a, s1_a, s0_a}); end
    endtask

    task automatic test_down();
        mode_down = 1; load = 1; ld_s0 = 4'd0; ld_s1 = 4'd0; ld_min = 8'h01;
        clk_step(); load = 0;
        for (int c = 0; c < 4; c++) clk_step();
        checks++;
        if ({min_a, s1_a, s0_a, tick_a} !== {16'h0059, 1'b1}) begin errors++;
            $display("FAIL down_borrow got %h t%b want 0059 t1", {min_a, s1_a, s0_a}, tick_a); end
        load = 1; ld_s0 = 4'd2; ld_s1 = 4'd0; ld_min = 8'h00;
        clk_step(); load = 0;
        for (int c = 1; c <= 16; c++) begin
            clk_step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin errors++;
                    $display("FAIL down c%0d dut%0d got %h want %h", c, k, obs(k), expv(k)); end
            end
        end
        checks++;
        if ({min_b, s1_b, s0_b, done_a, done_b} !== {16'h0000, 2'b11}) begin errors++;
            $display("FAIL down_hold got %h d%b%b want 0000 d11", {min_b, s1_b, s0_b}, done_a, done_b); end
        mode_down = 0;
    endtask

    task automatic test_clamp_priority();
        count = 0; load = 1; ld_s1 = 4'd7; ld_s0 = 4'd12; ld_min = 8'h3A;
        clk_step(); load = 0;
        checks++;
        if ({min_a, s1_a, s0_a} !== 16'h3959 || {min_b, s1_b, s0_b} !== 16'h3959) begin errors++;
            $display("FAIL clamp got %h %h want 3959", {min_a, s1_a, s0_a}, {min_b, s1_b, s0_b}); end
        count = 1;
        for (int c = 0; c < 3; c++) clk_step();
        load = 1; ld_s1 = 4'd0; ld_s0 = 4'd5; ld_min = 8'h00;
        clk_step(); load = 0;
        checks++;
        if ({min_a, s1_a, s0_a, tick_a} !== {16'h0005, 1'b0}) begin errors++;
            $display("FAIL load_over_tick got %h t%b want 0005 t0", {min_a, s1_a, s0_a}, tick_a); end
        for (int c = 1; c <= 4; c++) begin
            clk_step();
            checks++;
            if (obs(0) !== expv(0) || tick_a !== (c == 4)) begin errors++;
                $display("FAIL load_restart c%0d got %h want %h", c, obs(0), expv(0)); end
        end
    endtask

    task automatic test_reset_load();
        bit md;
        count = 1;
        for (int c = 0; c < 6; c++) clk_step();
        md = 1'($urandom);
        mode_down = md; reset = 1; load = 1; ld_s0 = 4'd3; ld_s1 = 4'd2; ld_min = 8'h11;
        clk_step(); reset = 0; load = 0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k) || obs(k)[18:3] !== 16'h0000) begin errors++;
                $display("FAIL reset_load dut%0d got %h want %h", k, obs(k), expv(k)); end
        end
        for (int c = 1; c <= 4; c++) begin
            clk_step();
            checks++;
            if (obs(1) !== expv(1)) begin errors++;
                $display("FAIL reset_load_run c%0d got %h want %h", c, obs(1), expv(1)); end
        end
        mode_down = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            count = ($urandom_range(0, 9) < 8);
            load  = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 49) == 0) mode_down = ~mode_down;
            if ($urandom_range(0, 1) == 0) begin
                ld_s0 = 4'($urandom); ld_s1 = 4'($urandom); ld_min = 8'($urandom);
            end else begin
                ld_s0 = 4'($urandom_range(7, 9)); ld_s1 = 4'd5; ld_min = 8'h99;
            end
            clk_step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin errors++;
                    $display("FAIL random c%0d dut%0d got %h want %h", c, k, obs(k), expv(k)); end
            end
        end
        reset = 0; load = 0;
    endtask

    initial begin
        m_presc = 0; m_tick = 0;
        for (int k = 0; k < 2; k++) begin m_secs[k] = 0; m_wrap[k] = 0; end
        #1;
        test_reset();
        test_count_up();
        test_pause();
        test_sat_wrap();
        test_down();
        test_clamp_priority();
        test_reset_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
